mips_fetch_unit: RTL and testbench

//  Instruction-side producer for the single-issue MIPS control decoder.
//  - Keeps the PC and fetches instruction words over a req/ack memory port.
//  - Holds each word in an instruction register (IR) and drives its opc/func and

---
 rtl/mips_fetch_unit_if.sv | 33 +++
 rtl/mips_fetch_unit.sv | 108 ++++++++++
 tb/tb_mips_fetch_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_unit_if.sv
// Bundle between the fetch unit, instruction memory and the control decoder.
// The fetch unit takes the master modport; memory/decoder/ALU side takes the slave modport.
interface mips_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [5:0]  opc;
   logic [5:0]  func;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [15:0] imm16;
   logic        instr_valid;
   logic        isJmp;
   logic        isBeq;
   logic        isBne;
   logic        invOpcode;
   logic        alu_zero;
   logic        stall;
   logic [31:0] pc;
   logic        trap;

   modport master (
      output imem_req, imem_addr, opc, func, rs, rt, rd, imm16, instr_valid, pc, trap,
      input  imem_ack, imem_rdata, isJmp, isBeq, isBne, invOpcode, alu_zero, stall
   );

   modport slave (
      input  imem_req, imem_addr, opc, func, rs, rt, rd, imm16, instr_valid, pc, trap,
      output imem_ack, imem_rdata, isJmp, isBeq, isBne, invOpcode, alu_zero, stall
   );
endinterface

// File: rtl/mips_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack port, holds the IR
// for the decoder and resolves jump/branch targets; traps stickily on an invalid opcode.
module mips_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
   input  logic              clk,
   input  logic              rst,
   mips_fetch_unit_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      EXEC  = 2'd2,
      TRAP  = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_ir;
   logic        r_imemReq;
   logic        r_instrValid;
   logic        r_trap;

   logic [31:0] w_pc4;
   logic [31:0] w_jmpTarget;
   logic [31:0] w_brTarget;
   logic        w_brTaken;
   logic [31:0] w_nextPc;

   // Both branch conditions are OR-ed so a decoder asserting isBeq and isBne together is still well defined.
   always_comb begin
      w_pc4       = r_pc + 32'd4;
      w_jmpTarget = {w_pc4[31:28], r_ir[25:0], 2'b00};
      w_brTarget  = w_pc4 + {{14{r_ir[15]}}, r_ir[15:0], 2'b00};
      w_brTaken   = (bus.isBeq & bus.alu_zero) | (bus.isBne & ~bus.alu_zero);
      if (bus.isJmp) begin
         w_nextPc = w_jmpTarget;
      end else if (w_brTaken) begin
         w_nextPc = w_brTarget;
      end else begin
         w_nextPc = w_pc4;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_pc         <= RESET_PC;
         r_ir         <= 32'd0;
         r_imemReq    <= 1'b0;
         r_instrValid <= 1'b0;
         r_trap       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_state   <= FETCH;
               r_imemReq <= 1'b1;
            end
            FETCH: begin
               if (bus.imem_ack) begin
                  r_ir         <= bus.imem_rdata;
                  r_state      <= EXEC;
                  r_imemReq    <= 1'b0;
                  r_instrValid <= 1'b1;
               end
            end
            EXEC: begin
               // Stall outranks invOpcode; pc stays on the offender when trapping.
               if (bus.stall) begin
                  r_state <= EXEC;
               end else if (bus.invOpcode) begin
                  r_state      <= TRAP;
                  r_instrValid <= 1'b0;
                  r_trap       <= 1'b1;
               end else begin
                  r_pc         <= w_nextPc;
                  r_state      <= FETCH;
                  r_imemReq    <= 1'b1;
                  r_instrValid <= 1'b0;
               end
            end
            TRAP: begin
               r_state      <= TRAP;
               r_imemReq    <= 1'b0;
               r_instrValid <= 1'b0;
               r_trap       <= 1'b1;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.imem_req    = r_imemReq;
   assign bus.imem_addr   = r_pc;
   assign bus.pc          = r_pc;
   assign bus.opc         = r_ir[31:26];
   assign bus.rs          = r_ir[25:21];
   assign bus.rt          = r_ir[20:16];
   assign bus.rd          = r_ir[15:11];
   assign bus.imm16       = r_ir[15:0];
   assign bus.func        = r_ir[5:0];
   assign bus.instr_valid = r_instrValid;
   assign bus.trap        = r_trap;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Scoreboard bench for mips_fetch_unit: a driver walks a directed program table and
// pushes expected fetch addresses / IR contents; a negedge monitor pops and compares.
module tb_mips_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0040_0000;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mips_fetch_unit_if bus ();

   mips_fetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Minimal decoder model: j=2, beq=4, bne=5, opcode 0x2a unsupported.
   assign bus.isJmp     = (bus.opc == 6'h02);
   assign bus.isBeq     = (bus.opc == 6'h04);
   assign bus.isBne     = (bus.opc == 6'h05);
   assign bus.invOpcode = (bus.opc == 6'h2a);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] word;
   } irExp_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] word;
      logic [3:0]  ackDelay;
      logic        aluZ;
      logic [3:0]  stallCyc;
   } vec_t;

   logic [31:0] expAddrQ[$];
   irExp_t      expIrQ[$];
   int          checks = 0;
   int          errors = 0;
   logic        monitorOn = 1'b0;

   vec_t vecs[20];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic waitReq();
      int n = 0;
      while (bus.imem_req !== 1'b1 && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (bus.imem_req !== 1'b1) begin
         checkOutput("req_timeout", {31'd0, bus.imem_req}, 32'd1);
      end
   endtask

   // Issue one instruction: fetch with ackDelay wait cycles, then hold EXEC for stallCyc cycles.
   task automatic applyStimulus(input vec_t v);
      expAddrQ.push_back(v.addr);
      expIrQ.push_back('{addr: v.addr, word: v.word});
      waitReq();
      repeat (int'(v.ackDelay)) begin
         @(posedge clk);
         #1;
      end
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = v.word;
      bus.alu_zero   = v.aluZ;
      bus.stall      = (v.stallCyc != 4'd0);
      @(posedge clk);
      #1;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'hDEAD_BEEF;
      repeat (int'(v.stallCyc)) begin
         @(posedge clk);
         #1;
      end
      bus.stall = 1'b0;
      @(posedge clk);
      #1;
      bus.alu_zero = 1'b0;
   endtask

   // Monitor: every requesting cycle must show the expected address; every EXEC cycle
   // must show the expected pc and IR fields (which also covers freezing under stall).
   initial begin
      irExp_t cur;
      logic   prevValid;
      cur       = '0;
      prevValid = 1'b0;
      forever begin
         @(negedge clk);
         if (monitorOn && rst === 1'b0) begin
            if (bus.imem_req === 1'b1) begin
               if (expAddrQ.size() == 0) begin
                  checkOutput("unexpected_fetch", bus.imem_addr, 32'hFFFF_FFFF);
               end else begin
                  checkOutput("imem_addr", bus.imem_addr, expAddrQ[0]);
                  if (bus.imem_ack === 1'b1) void'(expAddrQ.pop_front());
               end
            end
            if (bus.instr_valid === 1'b1) begin
               if (!prevValid) begin
                  if (expIrQ.size() == 0) begin
                     checkOutput("unexpected_exec", bus.pc, 32'hFFFF_FFFF);
                  end else begin
                     cur = expIrQ.pop_front();
                  end
               end
               checkOutput("exec_pc", bus.pc, cur.addr);
               checkOutput("ir_opc_rs_rt_imm", {bus.opc, bus.rs, bus.rt, bus.imm16}, cur.word);
               checkOutput("ir_rd_func", {21'd0, bus.rd, bus.func}, {21'd0, cur.word[15:11], cur.word[5:0]});
            end
            prevValid = (bus.instr_valid === 1'b1);
         end else begin
            prevValid = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      vecs[0]  = '{32'h0040_0000, 32'h0109_5024, 4'd0, 1'b0, 4'd0};
      vecs[1]  = '{32'h0040_0004, 32'h0000_0020, 4'd3, 1'b0, 4'd0};
      vecs[2]  = '{32'h0040_0008, 32'h0000_0020, 4'd1, 1'b0, 4'd0};
      vecs[3]  = '{32'h0040_000C, 32'h0000_0020, 4'd0, 1'b0, 4'd0};
      vecs[4]  = '{32'h0040_0010, 32'h1400_FFFC, 4'd0, 1'b0, 4'd0};
      vecs[5]  = '{32'h0040_0004, 32'h0000_0020, 4'd0, 1'b0, 4'd0};
      vecs[6]  = '{32'h0040_0008, 32'h0000_0020, 4'd0, 1'b0, 4'd0};
      vecs[7]  = '{32'h0040_000C, 32'h0000_0020, 4'd0, 1'b0, 4'd0};
      vecs[8]  = '{32'h0040_0010, 32'h1400_FFFC, 4'd0, 1'b1, 4'd0};
      vecs[9]  = '{32'h0040_0014, 32'h0000_0020, 4'd0, 1'b0, 4'd0};
      vecs[10] = '{32'h0040_0018, 32'h0000_0020, 4'd0, 1'b0, 4'd0};
      vecs[11] = '{32'h0040_001C, 32'h0000_0020, 4'd0, 1'b0, 4'd0};
      vecs[12] = '{32'h0040_0020, 32'h0810_0040, 4'd0, 1'b0, 4'd0};
      vecs[13] = '{32'h0040_0100, 32'h1000_FFFF, 4'd0, 1'b1, 4'd0};
      vecs[14] = '{32'h0040_0100, 32'h1000_FFFF, 4'd0, 1'b0, 4'd0};
      vecs[15] = '{32'h0040_0104, 32'h0800_0000, 4'd0, 1'b0, 4'd0};
      vecs[16] = '{32'h0000_0000, 32'h0109_5024, 4'd0, 1'b0, 4'd5};
      vecs[17] = '{32'h0000_0004, 32'h1000_FFFD, 4'd0, 1'b1, 4'd0};
      vecs[18] = '{32'hFFFF_FFFC, 32'h0109_5024, 4'd0, 1'b0, 4'd5};
      vecs[19] = '{32'h0000_0000, 32'hA800_0000, 4'd0, 1'b0, 4'd2};

      rst            = 1'b1;
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'd0;
      bus.alu_zero   = 1'b0;
      bus.stall      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_req", {31'd0, bus.imem_req}, 32'd0);
      checkOutput("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
      checkOutput("rst_trap", {31'd0, bus.trap}, 32'd0);
      checkOutput("rst_pc", bus.pc, RESET_PC);
      checkOutput("rst_opc_func", {20'd0, bus.opc, bus.func}, 32'd0);

      monitorOn = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("idle_req", {31'd0, bus.imem_req}, 32'd0);
      @(posedge clk);
      #1;
      checkOutput("first_req", {31'd0, bus.imem_req}, 32'd1);
      checkOutput("first_addr", bus.imem_addr, RESET_PC);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(vecs[i]);
      end

      checkOutput("trap_set", {31'd0, bus.trap}, 32'd1);
      checkOutput("trap_req", {31'd0, bus.imem_req}, 32'd0);
      checkOutput("trap_valid", {31'd0, bus.instr_valid}, 32'd0);
      checkOutput("trap_pc", bus.pc, 32'h0000_0000);

      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'h0000_0020;
      repeat (2) @(posedge clk);
      #1;
      bus.imem_ack = 1'b0;
      checkOutput("trap_ack_ignored_opc", {26'd0, bus.opc}, 32'h0000_002a);
      checkOutput("trap_sticky", {31'd0, bus.trap}, 32'd1);
      checkOutput("trap_sticky_req", {31'd0, bus.imem_req}, 32'd0);

      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_clr_trap", {31'd0, bus.trap}, 32'd0);
      checkOutput("rst_clr_pc", bus.pc, RESET_PC);
      checkOutput("rst_clr_opc", {26'd0, bus.opc}, 32'd0);

      expAddrQ.push_back(RESET_PC);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("refetch_req", {31'd0, bus.imem_req}, 32'd1);
      #2;
      rst          = 1'b1;
      bus.imem_ack = 1'b1;
      #1;
      checkOutput("midfetch_rst_req", {31'd0, bus.imem_req}, 32'd0);
      expAddrQ.delete();
      @(posedge clk);
      #1;
      checkOutput("late_ack_ignored_opc", {26'd0, bus.opc}, 32'd0);
      @(negedge clk);
      bus.imem_ack = 1'b0;
      rst          = 1'b0;

      applyStimulus(vecs[0]);
      monitorOn = 1'b0;
      checkOutput("after_rst_next_addr", bus.imem_addr, 32'h0040_0004);
      checkOutput("sb_addr_drained", expAddrQ.size(), 32'd0);
      checkOutput("sb_ir_drained", expIrQ.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
